// File: rtl/memi_loader.sv
// memi_loader: write-side loader for the double-banked instruction memory.
// Streams host words into the write bank, then flips BANK (ping-pong) once the
// program is complete and the fetch side releases the read bank.
// Optional build macro MEMI_LOADER_CHK_EN adds the CHKSUM output (XOR of the
// accepted words of the program most recently swapped in).
//
// state     | meaning
// LOAD      | accepting host words, one write per accept
// DRAIN     | final write of the program on WA/DW/WCEB, no accepts
// WAIT_SWAP | program complete, waiting for RD_DONE to flip BANK
module memi_loader #(
    parameter int ADRS  = 14,
    parameter int BITS  = 128,
    parameter int WORDS = 8192
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [BITS-1:0]   S_DATA,
    input  logic              S_LAST,
    input  logic              RD_DONE,
    output logic [ADRS-1:0]   WA,
    output logic [2*BITS-1:0] DW,
    output logic              WCEB,
    output logic              BANK,
    output logic              SWAP,
    output logic [ADRS:0]     PROG_LEN,
    output logic              OVF
`ifdef MEMI_LOADER_CHK_EN
    ,
    output logic [BITS-1:0]   CHKSUM
`endif
);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        DRAIN     = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    // Index of the last word a bank can hold (2*WORDS == 2^ADRS).
    localparam logic [ADRS:0] LAST_CNT = (ADRS+1)'(2 * WORDS - 1);

    state_t        state;
    state_t        state_next;
    logic [ADRS:0] count;
    logic          accept;
    logic          at_full;
    logic          term;
    logic          do_swap;
    logic          ready_next;

    assign accept  = S_VALID & S_READY & (state == LOAD);
    assign at_full = (count == LAST_CNT);

    // Next-state and per-cycle strobes; S_READY is precomputed one cycle ahead.
    always_comb begin
        state_next = state;
        ready_next = 1'b0;
        term       = 1'b0;
        do_swap    = 1'b0;
        case (state)
            LOAD: begin
                term       = accept & (S_LAST | at_full);
                ready_next = ~term;
                if (term) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (RD_DONE) begin
                    do_swap    = 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Registered memory write port, bank control and program bookkeeping.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            S_READY  <= 1'b0;
            WA       <= '0;
            DW       <= '0;
            WCEB     <= 1'b1;
            BANK     <= 1'b0;
            SWAP     <= 1'b0;
            PROG_LEN <= '0;
            OVF      <= 1'b0;
            count    <= '0;
        end else begin
            S_READY <= ready_next;
            WCEB    <= ~accept;
            SWAP    <= do_swap;
            if (accept) begin
                WA    <= count[ADRS-1:0];
                DW    <= {S_DATA, S_DATA};
                count <= count + (ADRS+1)'(1);
                // Bank filled without an end marker: truncate and flag it.
                if (at_full && !S_LAST) begin
                    OVF <= 1'b1;
                end
            end
            if (do_swap) begin
                BANK     <= ~BANK;
                PROG_LEN <= count;
                count    <= '0;
            end
        end
    end

`ifdef MEMI_LOADER_CHK_EN
    logic [BITS-1:0] chk_acc;

    // Running XOR of the program being loaded, published at swap.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            chk_acc <= '0;
            CHKSUM  <= '0;
        end else if (do_swap) begin
            CHKSUM  <= chk_acc;
            chk_acc <= '0;
        end else if (accept) begin
            chk_acc <= chk_acc ^ S_DATA;
        end
    end
`endif

endmodule
